// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin burst arbiter and its helpers:
// state encoding, default sizing and a one-hot decode helper.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_TIMEOUT = 15;

    // Callers truncate to their own requester count (at most 32 requesters).
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ (non-power-of-two counts supported).
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  pick,
    output logic             any
);

    logic [ID_W-1:0] cand [N_REQ];

    // cand[gi] is the requester examined at scan offset gi from ptr.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [ID_W:0] sum;
        assign sum      = {1'b0, ptr} + (ID_W+1)'(gi);
        assign cand[gi] = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                    : sum[ID_W-1:0];
    end

    always_comb begin
        pick = '0;
        any  = 1'b0;
        // Scan from the far end so the closest offset to ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                pick = cand[i];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that holds a grant for a whole burst, counting accepted
// beats, and releases on the last beat or after a stall timeout.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ   = DEF_N_REQ,
    parameter  int LEN_W   = DEF_LEN_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic                   beat,
    output logic [N_REQ-1:0]       gnt,
    output logic [ID_W-1:0]        gnt_id,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    localparam logic [7:0]      STALL_LAST = 8'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(N_REQ - 1);

    arb_state_e       state_q,       state_d;
    logic [ID_W-1:0]  ptr_q,         ptr_d;
    logic [N_REQ-1:0] gnt_q,         gnt_d;
    logic [ID_W-1:0]  gnt_id_q,      gnt_id_d;
    logic [LEN_W-1:0] len_q,         len_d;
    logic [LEN_W-1:0] beat_cnt_q,    beat_cnt_d;
    logic [7:0]       stall_cnt_q,   stall_cnt_d;
    logic             done_q,        done_d;
    logic             timeout_err_q, timeout_err_d;

    logic [ID_W-1:0]  pick;
    logic             any;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    // Priority restarts just after the requester that was last served.
    assign next_ptr = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        done_d        = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(onehot(32'(pick)));
                    gnt_id_d    = pick;
                    len_d       = req_len[32'(pick)*LEN_W +: LEN_W];
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            GRANT: begin
                // A beat always wins over a timeout landing in the same cycle.
                if (beat) begin
                    stall_cnt_d = '0;
                    if (beat_cnt_q == len_q) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = next_ptr;
                        done_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (stall_cnt_q == STALL_LAST) begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    ptr_d         = next_ptr;
                    timeout_err_d = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = (state_q == GRANT);
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (N_REQ=4, LEN_W=4, TIMEOUT=15); each task
// drives one scenario and checks outputs 1ns after the rising edge.
module tb_rr_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_len = '0;
    logic        beat = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    rr_burst_arbiter #(.N_REQ(4), .LEN_W(4), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_len     (req_len),
        .beat        (beat),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Finish any open burst; an arbiter that never releases counts as a failure.
    task automatic drain();
        req  = '0;
        beat = 1'b1;
        for (int i = 0; i < 40 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain busy=%b required 0 within 40 cycles", busy);
        end
        beat = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({gnt, gnt_id, busy, done, timeout_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset gnt/id/busy/done/to=%b required 000000000",
                     {gnt, gnt_id, busy, done, timeout_err});
        end
        rst = 1'b0;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_single();
        logic [3:0] exp_gnt  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        logic       exp_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        req     = 4'b0001;
        req_len = 16'h0002;
        beat    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({gnt, busy, done, gnt_id} !== {exp_gnt[i], |exp_gnt[i], exp_done[i], 2'd0}) begin
                errors++;
                $display("FAIL single_c%0d gnt/busy/done/id=%b required %b", i + 1,
                         {gnt, busy, done, gnt_id}, {exp_gnt[i], |exp_gnt[i], exp_done[i], 2'd0});
            end
        end
        drain();
        $display("test_single: 3-beat burst, bubble and regrant checked");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        logic [1:0] exp_id  [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        int n_done = 0;
        do_reset();
        req     = 4'b1111;
        req_len = 16'h0000;
        beat    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i > 0 && done === 1'b1) n_done++;
            checks++;
            if ({gnt, gnt_id, done} !== {exp_gnt[i], exp_id[i], (i % 2 == 1)}) begin
                errors++;
                $display("FAIL rr_c%0d gnt/id/done=%b required %b", i + 1,
                         {gnt, gnt_id, done}, {exp_gnt[i], exp_id[i], (i % 2 == 1)});
            end
        end
        checks++;
        if (n_done !== 4) begin
            errors++;
            $display("FAIL rr_done_count got %0d required 4", n_done);
        end
        drain();
        $display("test_round_robin: order 0,1,2,3,0 checked");
    endtask

    task automatic test_timeout();
        do_reset();
        req     = 4'b0100;
        req_len = 16'h0300;
        beat    = 1'b0;
        tick();
        checks++;
        if ({gnt, gnt_id, busy} !== {4'b0100, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL to_grant gnt/id/busy=%b required 0100101", {gnt, gnt_id, busy});
        end
        req = 4'b1100;
        for (int c = 2; c <= 15; c++) begin
            tick();
            checks++;
            if ({gnt, timeout_err, done} !== {4'b0100, 2'b00}) begin
                errors++;
                $display("FAIL to_hold_c%0d gnt/to/done=%b required 010000", c,
                         {gnt, timeout_err, done});
            end
        end
        tick();
        checks++;
        if ({gnt, busy, timeout_err, done} !== 7'b0000_0_1_0) begin
            errors++;
            $display("FAIL to_c16 gnt/busy/to/done=%b required 0000010",
                     {gnt, busy, timeout_err, done});
        end
        tick();
        checks++;
        if ({gnt, gnt_id, timeout_err} !== {4'b1000, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL to_next gnt/id/to=%b required 1000110", {gnt, gnt_id, timeout_err});
        end
        drain();
        $display("test_timeout: release on cycle 16 and handoff to 3 checked");
    endtask

    task automatic test_beat_beats_timeout();
        do_reset();
        req     = 4'b0001;
        req_len = 16'h0002;
        beat    = 1'b0;
        tick();
        for (int c = 2; c <= 15; c++) tick();
        beat = 1'b1;
        tick();
        checks++;
        if ({gnt, busy, timeout_err, done} !== 7'b0001_1_0_0) begin
            errors++;
            $display("FAIL beat_prio gnt/busy/to/done=%b required 0001100",
                     {gnt, busy, timeout_err, done});
        end
        beat = 1'b0;
        tick();
        checks++;
        if ({gnt, timeout_err} !== 5'b0001_0) begin
            errors++;
            $display("FAIL beat_prio_after gnt/to=%b required 00010", {gnt, timeout_err});
        end
        drain();
        $display("test_beat_beats_timeout: beat on stall limit keeps grant");
    endtask

    task automatic test_hold();
        do_reset();
        req     = 4'b0001;
        req_len = 16'h0001;
        beat    = 1'b0;
        tick();
        req     = 4'b0000;
        req_len = 16'hFFFF;
        tick();
        checks++;
        if ({gnt, done} !== 5'b0001_0) begin
            errors++;
            $display("FAIL hold_dropreq gnt/done=%b required 00010", {gnt, done});
        end
        beat = 1'b1;
        tick();
        checks++;
        if ({gnt, done} !== 5'b0001_0) begin
            errors++;
            $display("FAIL hold_beat1 gnt/done=%b required 00010", {gnt, done});
        end
        tick();
        checks++;
        if ({gnt, busy, done} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL hold_beat2 gnt/busy/done=%b required 000001", {gnt, busy, done});
        end
        beat = 1'b0;
        tick();
        checks++;
        if ({gnt, done} !== 5'b0000_0) begin
            errors++;
            $display("FAIL hold_after gnt/done=%b required 00000", {gnt, done});
        end
        $display("test_hold: req drop and req_len change ignored");
    endtask

    task automatic test_async_reset();
        do_reset();
        req     = 4'b0010;
        req_len = 16'h0050;
        beat    = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL arst_pre gnt=%b required 0010", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, busy, done, timeout_err} !== 7'b0) begin
            errors++;
            $display("FAIL arst_mid gnt/busy/done/to=%b required 0000000",
                     {gnt, busy, done, timeout_err});
        end
        #1;
        rst     = 1'b0;
        req     = 4'b1111;
        req_len = 16'h0000;
        beat    = 1'b0;
        tick();
        checks++;
        if ({gnt, gnt_id} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL arst_ptr gnt/id=%b required 000100", {gnt, gnt_id});
        end
        drain();
        $display("test_async_reset: immediate drop and ptr restart checked");
    endtask

    task automatic test_idle_beats();
        do_reset();
        req  = 4'b0000;
        beat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({gnt, busy, done} !== 6'b0) begin
                errors++;
                $display("FAIL idle_beat%0d gnt/busy/done=%b required 000000", i,
                         {gnt, busy, done});
            end
        end
        req     = 4'b0100;
        req_len = 16'h0000;
        beat    = 1'b0;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, done} !== 5'b0100_0) begin
            errors++;
            $display("FAIL idle_held gnt/done=%b required 01000", {gnt, done});
        end
        beat = 1'b1;
        tick();
        checks++;
        if ({gnt, done} !== 5'b0000_1) begin
            errors++;
            $display("FAIL idle_end gnt/done=%b required 00001", {gnt, done});
        end
        beat = 1'b0;
        $display("test_idle_beats: idle beats not counted");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_beat_beats_timeout();
        test_hold();
        test_async_reset();
        test_idle_beats();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Shares the single datapath resource inside top between N_REQ requesters using round-robin arbitration.
- Holds one grant for a whole burst, counts the beats the resource accepts, and releases on the last beat.
- Also releases on a stall timeout.
- Sits between requester logic and the resource's beat/accept interface; top instantiates one per shared resource.

Parameters:
- N_REQ, 4, number of requesters (>=2; non-power-of-two allowed).
- LEN_W, 4, width of each burst-length field; a value L means L+1 beats.
- TIMEOUT, 15, consecutive no-beat cycles in a grant before forced release (>=1, fits 8 bits).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- req_len  input  N_REQ*LEN_W  packed burst lengths; requester i uses bits [i*LEN_W +: LEN_W].
- beat  input  1  resource accepted one beat from the current grantee this cycle.
- gnt  output  N_REQ  one-hot grant, registered.
- gnt_id  output  $clog2(N_REQ)  index of the grantee; valid while busy.
- busy  output  1  a grant is active.
- done  output  1  one-cycle pulse after a burst completes normally.
- timeout_err  output  1  one-cycle pulse after a timeout release.

Behaviour:
- Reset (async, immediate): gnt=0, gnt_id=0, busy=0, done=0, timeout_err=0, state=IDLE, ptr=0, beat_cnt=0, stall_cnt=0, len_q=0.
- States: IDLE, GRANT.
- IDLE:
  - If |req, pick the first set req scanning ptr, ptr+1, … mod N_REQ.
  - Next edge: gnt=onehot(pick), gnt_id=pick, busy=1, len_q=req_len[pick], beat_cnt=0, stall_cnt=0, state=GRANT.
  - Latency from req to gnt: 1 cycle.
  - beat is ignored in IDLE.
- GRANT, beat=1:
  - stall_cnt clears.
  - If beat_cnt==len_q: next edge gnt=0, busy=0, done=1, ptr=(gnt_id+1) mod N_REQ, state=IDLE.
  - Otherwise beat_cnt increments.
- GRANT, beat=0:
  - stall_cnt increments.
  - When stall_cnt==TIMEOUT-1 and beat=0: next edge gnt=0, busy=0, timeout_err=1, done=0, ptr advances as above, state=IDLE.
- A beat on the timeout cycle takes priority over the timeout: it counts, and no timeout occurs.
- req deassertion during GRANT is ignored; the grant holds until completion or timeout.
- req_len is sampled only at grant; later changes are ignored.
- done and timeout_err are high for exactly one cycle: the IDLE cycle in which the next arbitration is evaluated.
- Back-to-back grants therefore have a 1-cycle bubble with gnt=0.
- Round-robin fairness: under continuous contention, each active requester is granted within N_REQ grants.
- ptr wraps from N_REQ-1 to 0.
- A single requester holding req continuously is regranted every (beats+1) cycles.
- len_q = 2^LEN_W-1 gives a 2^LEN_W-beat burst; beat_cnt is LEN_W bits wide and never wraps.
- Reset asserted mid-burst drops gnt in the same cycle, with no done or timeout_err.
- Invariants: gnt is one-hot or zero; busy == |gnt.

Decomposition:
- Package arb_pkg holds:
  - state enum arb_state_e {IDLE, GRANT};
  - default parameter constants;
  - the function onehot(idx).
- One combinational sub-module, rr_pick, takes (req, ptr) and returns (pick, any).
- rr_pick is reused by other shared resources in top.

Test Plan:
- Reset, then req=4'b0001 with len0=2 and beat=1 continuously:
  - gnt=0001 one cycle after req;
  - 3 beats;
  - done pulses; gnt=0 for 1 cycle;
  - gnt=0001 again.
- req=4'b1111, all lens=0, beat=1 held: grant order 0,1,2,3,0; done pulses 4 times in 8 cycles after the first grant.
- Grant to requester 2 with len=3, then beat=0 for 15 cycles: timeout_err pulses on cycle 16, done stays 0, next grant goes to 3 if requested.
- Grant with len=1; drop req and change req_len right after the grant: grant holds; exactly 2 beats are required; done after the second beat.
- Assert rst asynchronously mid-burst (between edges): gnt, busy, done all drop immediately; after release, requester 0 has priority again (ptr=0).
- beat pulses while IDLE, then a grant with len=0: the earlier beats are not counted; the burst ends on the first post-grant beat.
